// File: rtl/mul_seq.sv
// Iterative shift-add multiplier for the execute stage.
//
// A MUL in E is captured in IDLE, then RUN consumes RADIX_BITS multiplier
// bits per cycle until the remaining multiplier is zero or all steps are
// used. DONE holds the low XLEN bits of the product until M accepts it.
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   E_mul       a MUL occupies the E stage
//   E_a, E_b    multiplicand and multiplier after forwarding
//   E_rd        destination register of the MUL
//   flush       branch flush; aborts any operation in flight
//   out_ready   M stage accepts a result this cycle
//   stall       freeze F/D/E pipeline registers
//   busy        sequencer is not idle
//   M_valid     result transferred to M this cycle
//   M_result    low XLEN bits of E_a*E_b
//   M_rd        destination register of the result
module mul_seq #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            E_mul,
  input  logic [XLEN-1:0] E_a,
  input  logic [XLEN-1:0] E_b,
  input  logic [4:0]      E_rd,
  input  logic            flush,
  input  logic            out_ready,
  output logic            stall,
  output logic            busy,
  output logic            M_valid,
  output logic [XLEN-1:0] M_result,
  output logic [4:0]      M_rd
);

  localparam int unsigned Steps = XLEN / RADIX_BITS;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] acc_q, mcand_q, mplier_q;
  logic [4:0]      rd_q;
  logic [CntW-1:0] cnt_q;

  logic [XLEN-1:0] partial, acc_step, mcand_step, mplier_step;
  logic [CntW-1:0] cnt_step;

  // Product of mcand and the low RADIX_BITS multiplier digit, mod 2^XLEN.
  always_comb begin
    partial = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier_q[i]) partial = partial + (mcand_q << i);
    end
  end

  assign acc_step    = acc_q + partial;
  assign mcand_step  = mcand_q << RADIX_BITS;
  assign mplier_step = mplier_q >> RADIX_BITS;
  assign cnt_step    = cnt_q - 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (E_mul) state_d = (E_b == '0) ? StDone : StRun;
      end
      StRun: begin
        if (mplier_step == '0 || cnt_step == '0) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else if (!flush) begin
      if (state_q == StIdle && E_mul) begin
        acc_q    <= '0;
        mcand_q  <= E_a;
        mplier_q <= E_b;
        rd_q     <= E_rd;
        cnt_q    <= CntW'(Steps);
      end else if (state_q == StRun) begin
        acc_q    <= acc_step;
        mcand_q  <= mcand_step;
        mplier_q <= mplier_step;
        cnt_q    <= cnt_step;
      end
    end
  end

  // Outputs. The MUL leaves E exactly on the transfer edge.
  always_comb begin
    busy     = (state_q != StIdle);
    M_valid  = (state_q == StDone) && out_ready && !flush;
    stall    = E_mul && !((state_q == StDone) && out_ready);
    M_result = acc_q;
    M_rd     = rd_q;
  end

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        E_mul;
  logic [31:0] E_a, E_b;
  logic [4:0]  E_rd;
  logic        flush;
  logic        out_ready;

  logic        stall1, busy1, valid1, stall2, busy2, valid2;
  logic [31:0] res1, res2;
  logic [4:0]  rd1, rd2;

  logic        sel;  // 0: radix-1 instance, 1: radix-2 instance
  logic        v_stall, v_busy, v_valid;
  logic [31:0] v_res;
  logic [4:0]  v_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_seq #(.XLEN(32), .RADIX_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .E_mul(E_mul), .E_a(E_a), .E_b(E_b), .E_rd(E_rd),
    .flush(flush), .out_ready(out_ready), .stall(stall1), .busy(busy1),
    .M_valid(valid1), .M_result(res1), .M_rd(rd1)
  );

  mul_seq #(.XLEN(32), .RADIX_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .E_mul(E_mul), .E_a(E_a), .E_b(E_b), .E_rd(E_rd),
    .flush(flush), .out_ready(out_ready), .stall(stall2), .busy(busy2),
    .M_valid(valid2), .M_result(res2), .M_rd(rd2)
  );

  assign v_stall = sel ? stall2 : stall1;
  assign v_busy  = sel ? busy2  : busy1;
  assign v_valid = sel ? valid2 : valid1;
  assign v_res   = sel ? res2   : res1;
  assign v_rd    = sel ? rd2    : rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+2, outputs are sampled at posedge+3.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Issues one MUL with out_ready=1 and follows it to the transfer.
  // lat is the index of the transfer cycle (capture cycle = 0); stall must
  // be high in every cycle before it. Returns just after the transfer edge.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int  hi = 0;
    bit  done = 0;
    E_mul = 1'b1; E_a = a; E_b = b; E_rd = rd; out_ready = 1'b1;
    for (int t = 0; t < 80 && !done; t++) begin
      #1;
      if (v_valid) begin
        chk({tag, "_lat"}, t, lat);
        chk({tag, "_stall_hi"}, hi, lat);
        chk({tag, "_result"}, v_res, exp);
        chk({tag, "_rd"}, {27'd0, v_rd}, {27'd0, rd});
        chk({tag, "_stall_xfer"}, {31'd0, v_stall}, 32'd0);
        done = 1;
      end else if (v_stall) begin
        hi++;
      end
      cyc();
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1; E_mul = 1'b0; E_a = '0; E_b = '0; E_rd = '0;
    flush = 1'b0; out_ready = 1'b0;
    #22;
    chk("rst_valid", {31'd0, valid1}, 32'd0);
    chk("rst_result", res1, 32'd0);
    chk("rst_rd", {27'd0, rd1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_stall", {31'd0, stall1}, 32'd0);
    rst = 1'b0;
    cyc();

    // 7 * 2^31 = 0x3_8000_0000 -> 0x80000000; 32 RUN cycles.
    run_mul("msb", 32'd7, 32'h8000_0000, 5'd5, 32'h8000_0000, 33);
    E_mul = 1'b0;
    #1;
    chk("msb_idle_busy", {31'd0, busy1}, 32'd0);
    chk("msb_idle_valid", {31'd0, valid1}, 32'd0);
    cyc();

    run_mul("small", 32'h1234, 32'd3, 5'd9, 32'h369C, 3);
    run_mul("wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h1, 33);
    run_mul("zero", 32'h55, 32'd0, 5'd2, 32'd0, 1);
    E_mul = 1'b0;
    cyc();

    // Hold: 3*5, multiplier 101b -> 3 RUN cycles, DONE reached at t4.
    E_mul = 1'b1; E_a = 32'd3; E_b = 32'd5; E_rd = 5'd7; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_busy", {31'd0, busy1}, 32'd1);
      chk("hold_stall", {31'd0, stall1}, 32'd1);
      chk("hold_valid", {31'd0, valid1}, 32'd0);
      chk("hold_result", res1, 32'd15);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    chk("hold_xfer_valid", {31'd0, valid1}, 32'd1);
    chk("hold_xfer_stall", {31'd0, stall1}, 32'd0);
    chk("hold_xfer_result", res1, 32'd15);
    chk("hold_xfer_rd", {27'd0, rd1}, 32'd7);
    cyc();
    E_mul = 1'b0;
    #1;
    chk("hold_after_busy", {31'd0, busy1}, 32'd0);
    chk("hold_after_valid", {31'd0, valid1}, 32'd0);
    cyc();

    // Flush mid-RUN.
    E_mul = 1'b1; E_a = 32'd1; E_b = 32'hFFFF; E_rd = 5'd3;
    cyc(); cyc();
    flush = 1'b1;
    #1;
    chk("flush_busy_before", {31'd0, busy1}, 32'd1);
    chk("flush_valid", {31'd0, valid1}, 32'd0);
    cyc();
    flush = 1'b0; E_mul = 1'b0;
    #1;
    chk("flush_busy_after", {31'd0, busy1}, 32'd0);
    chk("flush_valid_after", {31'd0, valid1}, 32'd0);
    cyc();

    // Asynchronous reset mid-RUN: 2 * 0xFF, acc nonzero after a few steps.
    E_mul = 1'b1; E_a = 32'd2; E_b = 32'hFF; E_rd = 5'd11;
    cyc(); cyc(); cyc();
    #1;
    chk("arst_busy_before", {31'd0, busy1}, 32'd1);
    E_mul = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid1}, 32'd0);
    chk("arst_result", res1, 32'd0);
    chk("arst_rd", {27'd0, rd1}, 32'd0);
    chk("arst_busy", {31'd0, busy1}, 32'd0);
    chk("arst_stall", {31'd0, stall1}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Radix-2 back-to-back: 6 = 110b and 9 = 1001b each need 2 RUN cycles.
    sel = 1'b1;
    run_mul("r2_5x6", 32'd5, 32'd6, 5'd4, 32'd30, 3);
    run_mul("r2_9x9", 32'd9, 32'd9, 5'd8, 32'd81, 3);
    E_mul = 1'b0;
    #1;
    chk("r2_idle_busy", {31'd0, busy2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
